// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Holds the in-flight destination entry record, the register-file select
// code and the saturating counter increment used by the optional stats.
package fwd_pkg;

  // Widest register address an entry can hold; REG_W must not exceed this.
  localparam int FWD_DEST_W = 8;

  // Select code meaning "read the register file, no forwarding".
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                  vld;
    logic [FWD_DEST_W-1:0] dest;
    logic                  wb_en;
    logic                  is_load;
  } fwd_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand priority match of one EXE source against the in-flight entries.
// Latency: purely combinational. Backpressure: none, evaluated every cycle.
// Ports: entries (stage 1 at index 0), src/src_vld in; sel (0 = register
//        file, k = stage k) and hazard (youngest producer is an unready load) out.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH            = 2,
  parameter int REG_W            = 5,
  parameter int LOAD_READY_STAGE = 2,
  parameter int SEL_W            = 2
) (
  input  fwd_entry_t [DEPTH-1:0] entries,
  input  logic [REG_W-1:0]       src,
  input  logic                   src_vld,
  output logic [SEL_W-1:0]       sel,
  output logic                   hazard
);

  logic [SEL_W-1:0]      hit_sel;
  logic                  hit_load;
  logic [FWD_DEST_W-1:0] src_ext;

  assign src_ext = FWD_DEST_W'(src);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_sel  = SEL_W'(FWD_SEL_RF);
    hit_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (src_vld && (src != '0) && entries[k-1].vld && entries[k-1].wb_en &&
          (entries[k-1].dest == src_ext)) begin
        hit_sel  = SEL_W'(k);
        hit_load = entries[k-1].is_load;
      end
    end
  end

  // hit_load can only be set by a real match, so hit_sel is nonzero here.
  assign hazard = hit_load && (hit_sel < SEL_W'(LOAD_READY_STAGE));

  // A hazarding operand must not consume stale forwarded data.
  assign sel = hazard ? SEL_W'(FWD_SEL_RF) : hit_sel;

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding select and load-use stall for EXE operands from a DEPTH-stage record pipeline.
// Latency: outputs combinational from inputs and registered entries; entries shift 1/cycle.
// Backpressure: hold freezes all entries; stall injects a bubble into stage 1.
// Ports: src_EXE/src_vld_EXE/dest_EXE/WB_EN_EXE/MEM_R_EN_EXE/flush_EXE/hold in;
//        fwd_sel (per operand), stall out; stall_cnt/fwd_cnt only with FWD_STATS_EN.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int NUM_SRC          = 3,
  parameter  int REG_W            = 5,
  parameter  int DEPTH            = 2,
  parameter  int LOAD_READY_STAGE = 2,
  localparam int SEL_W            = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*REG_W-1:0] src_EXE,
  input  logic [NUM_SRC-1:0]       src_vld_EXE,
  input  logic [REG_W-1:0]         dest_EXE,
  input  logic                     WB_EN_EXE,
  input  logic                     MEM_R_EN_EXE,
  input  logic                     flush_EXE,
  input  logic                     hold,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              fwd_cnt
`endif
);

  fwd_entry_t [DEPTH-1:0] entries;
  logic [NUM_SRC-1:0]     hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_match #(
      .DEPTH           (DEPTH),
      .REG_W           (REG_W),
      .LOAD_READY_STAGE(LOAD_READY_STAGE),
      .SEL_W           (SEL_W)
    ) u_match (
      .entries(entries),
      .src    (src_EXE[i*REG_W +: REG_W]),
      .src_vld(src_vld_EXE[i]),
      .sel    (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard (hazard[i])
    );
  end

  assign stall = |hazard;

  // The stalled EXE instruction stays in EXE, so stage 1 gets a bubble rather
  // than a duplicate of it. Under hold nothing moves, so no bubble either.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries <= '0;
    end else if (!hold) begin
      for (int k = 1; k < DEPTH; k++) begin
        entries[k] <= entries[k-1];
      end
      if (flush_EXE || stall) begin
        entries[0] <= '0;
      end else begin
        entries[0] <= '{vld: 1'b1, dest: FWD_DEST_W'(dest_EXE),
                        wb_en: WB_EN_EXE, is_load: MEM_R_EN_EXE};
      end
    end
  end

`ifdef FWD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!hold) begin
      if (stall) stall_cnt <= sat_inc16(stall_cnt);
      if (|fwd_sel) fwd_cnt <= sat_inc16(fwd_cnt);
    end
  end
`endif

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core, sitting beside the EXE stage. It owns a DEPTH-entry shift pipeline of in-flight destination records (MEM, WB, and optional further stages) instead of taking per-stage destination ports. For each of NUM_SRC EXE source operands it produces a forwarding select, never forwards register 0, and raises a load-use stall when the youngest producer is a load whose data is not yet available.

## Interface
- NUM_SRC, 3, EXE source operands tracked (0 = val1, 1 = val2, 2 = store value)
- REG_W, 5, register address width
- DEPTH, 2, tracked post-EXE stages (stage 1 = MEM, stage 2 = WB, ...); range 1..7
- LOAD_READY_STAGE, 2, first stage whose load data may be forwarded; range 1..DEPTH
- SEL_W, $clog2(DEPTH+1), derived select width; not overridable
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- src_EXE  in  NUM_SRC*REG_W  source register addresses, operand i at [i*REG_W +: REG_W]
- src_vld_EXE  in  NUM_SRC  operand i is actually read by the EXE instruction
- dest_EXE  in  REG_W  destination of the EXE instruction
- WB_EN_EXE  in  1  EXE instruction writes the register file
- MEM_R_EN_EXE  in  1  EXE instruction is a load
- flush_EXE  in  1  EXE instruction is squashed
- hold  in  1  downstream freeze; whole tracking pipeline holds
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = forward from stage k
- stall  out  1  load-use hazard; upstream holds IF/ID/EXE this cycle

## Operation
- Entry per stage k: vld, dest, wb_en, is_load. Entry k matches operand i when vld && wb_en && dest == src_i && src_i != 0 && src_vld_EXE[i].
- fwd_sel[i]: smallest matching k; 0 if no match. Youngest producer always wins.
- Hazard on operand i: youngest match k has is_load and k < LOAD_READY_STAGE. stall = OR over operands. When the youngest match is an unready load, an older match is ignored.
- While stall = 1, fwd_sel of a hazarding operand is forced to 0. Other operands keep their normal select.
- Shift per edge, when hold = 0:
  - Stage k>1 takes entry k-1.
  - Stage 1 takes {1, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE}.
  - Stage 1 takes a bubble (vld = 0) when flush_EXE = 1 or stall = 1.
- hold = 1: all entries keep their value. Outputs are still evaluated from held entries and current inputs.
- hold and stall together: hold wins; no bubble is inserted.
- WB_EN_EXE = 0 entries still shift, but never match.

## Timing
- fwd_sel and stall are combinational from current inputs plus registered entries, with no added latency. The EXE instruction sees producers issued 1..DEPTH cycles earlier.
- Load followed immediately by a dependent instruction (defaults): 1 stall cycle, then fwd_sel = 2 on the next cycle.
- Reset (any time, including mid-stall): all entries vld = 0 immediately. fwd_sel = 0 and stall = 0 for any inputs until the first post-reset shift.
- Entries leave after stage DEPTH; nothing forwards older than DEPTH cycles.

## Configuration
- FWD_STATS_EN defined adds outputs stall_cnt and fwd_cnt, each 16 bits, saturating at 16'hFFFF, and cleared by rst_n.
  - stall_cnt counts cycles with stall = 1 and hold = 0.
  - fwd_cnt counts cycles with hold = 0 where any fwd_sel is nonzero.
- FWD_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package fwd_pkg holds:
  - the entry struct fwd_entry_t (vld, dest, wb_en, is_load);
  - localparam FWD_SEL_RF = 0;
  - the saturating-increment function used by the stats counters.
- One sub-module, fwd_match: a purely combinational per-operand priority match over the entry array, returning sel and hazard. It is instantiated NUM_SRC times via generate.

## Test plan
- ALU chain, defaults: add r3 issued, next cycle src_EXE op0 = 3 -> fwd_sel op0 = 1. One cycle later (no new writer) -> fwd_sel op0 = 2. Cycle after that -> 0.
- Two writers to r5 in back-to-back cycles -> dependent op1 = 5 gets fwd_sel = 1 (youngest), not 2.
- Load r7, then dependent op0 = 7 -> stall = 1 for exactly one cycle, with a bubble in stage 1. Next cycle stall = 0, fwd_sel op0 = 2.
- Writer to r0 with WB_EN_EXE = 1, then src = 0 -> fwd_sel = 0. Same for src_vld_EXE = 0 on a matching register.
- hold = 1 for 3 cycles after add r4 -> fwd_sel stays 1 throughout. flush_EXE on a load r9 -> no later stall or forward for r9.
- rst_n pulsed low mid-stall -> stall and fwd_sel drop to 0 asynchronously. With FWD_STATS_EN, stall_cnt reads 0, and after 70000 stall cycles reads 16'hFFFF.
